// File: rtl/program_loader.sv
// program_loader: fills a 16-word instruction memory from a byte stream, high byte first,
// while the CPU sees NOP_WORD on its fetch port and holds its PC.
module program_loader #(
  parameter int NWORDS = 16,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        load_end,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [3:0]  address,
  output logic [15:0] instruction,
  output logic        loading,
  output logic        load_done,
  output logic [4:0]  word_count
);
  typedef enum logic [1:0] {RUN, HI, LO, FINISH} state_t;
  state_t      state;
  logic [15:0] mem [NWORDS];
  logic [3:0]  wr_addr;
  logic [7:0]  hi_byte;
  logic        xfer;
  assign rx_ready    = (state == HI || state == LO) && !load_end;
  assign xfer        = rx_valid && rx_ready;
  assign loading     = state != RUN;
  assign load_done   = state == FINISH;
  assign instruction = loading ? NOP_WORD : mem[address];
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wr_addr    <= '0;
      hi_byte    <= '0;
      word_count <= '0;
      for (int i = 0; i < NWORDS; i++) mem[i] <= NOP_WORD;
    end else begin
      case (state)
        RUN: if (load_start) begin
          state      <= HI;
          wr_addr    <= '0;
          word_count <= '0;
        end
        HI: if (load_end) state <= FINISH;
          else if (xfer) begin
            hi_byte <= rx_data;
            state   <= LO;
          end
        LO: if (load_end) state <= FINISH;
          else if (xfer) begin
            mem[wr_addr] <= {hi_byte, rx_data};
            if (word_count != 5'd16) word_count <= word_count + 5'd1;
            // last entry ends the session instead of wrapping
            if (wr_addr == 4'(NWORDS - 1)) state <= FINISH;
            else begin
              wr_addr <= wr_addr + 4'd1;
              state   <= HI;
            end
          end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; expected writes are queued as bytes are driven
// and checked on the fetch port once the session ends.
module tb_program_loader;
  logic        clk = 0, rst = 1, load_start = 0, load_end = 0, rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic [3:0]  address = 0;
  logic        rx_ready, loading, load_done;
  logic [15:0] instruction;
  logic [4:0]  word_count;
  typedef struct {logic [3:0] a; logic [15:0] d;} wr_t;
  wr_t         q[$];
  logic [15:0] mdl [16];
  logic [3:0]  wa;
  int          n_chk = 0, n_pass = 0, pulses = 0, p0;
  program_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .address(address), .instruction(instruction), .loading(loading),
    .load_done(load_done), .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (load_done) pulses++;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    foreach (mdl[i]) mdl[i] = 16'h0000;
    q.delete();
  endtask
  task automatic pulse_start();
    load_start = 1;
    tick();
    load_start = 0;
    wa = 0;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1;
    #1;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("rx_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    rx_valid = 0;
  endtask
  task automatic send_pair(input logic [7:0] h, input logic [7:0] l, input int gap);
    send(h);
    repeat (gap) tick();
    send(l);
    repeat (gap) tick();
    mdl[wa] = {h, l};
    q.push_back('{a: wa, d: {h, l}});
    wa++;
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      #1;
      chk(tag, instruction, mdl[i]);
    end
  endtask
  task automatic end_session(input logic [4:0] exp_wc);
    int n = 0;
    wr_t e;
    while (loading && n < 50) begin
      tick();
      n++;
    end
    chk("end_timeout", n < 50, 1);
    chk("wc_end", word_count, exp_wc);
    while (q.size() > 0) begin
      e = q.pop_front();
      address = e.a;
      #1;
      chk("word", instruction, e.d);
    end
    sweep("sweep");
  endtask
  task automatic stop_session();
    load_end = 1;
    #1;
    chk("rdy_load_end", rx_ready, 0);
    tick();
    load_end = 0;
    chk("done_pulse", load_done, 1);
  endtask
  initial begin
    do_reset();
    chk("rst_ready", rx_ready, 0);
    chk("rst_loading", loading, 0);
    chk("rst_done", load_done, 0);
    chk("rst_wc", word_count, 0);
    sweep("rst_mem");
    pulse_start();
    chk("loading_on", loading, 1);
    send_pair(8'h12, 8'h02, 0);
    send_pair(8'hF2, 8'h00, 0);
    chk("wc2", word_count, 2);
    chk("still_loading", loading, 1);
    stop_session();
    end_session(2);
    do_reset();
    pulse_start();
    send_pair(8'h1E, 8'h0E, 0);
    send(8'hAB);
    rx_data = 8'hCD;
    rx_valid = 1;
    stop_session();
    rx_valid = 0;
    chk("wc_early", word_count, 1);
    end_session(1);
    pulse_start();
    send(8'h55);
    address = 0;
    #1;
    chk("nop_while_loading", instruction, 16'h0000);
    p0 = pulses;
    rx_valid = 1;
    rx_data = 8'h66;
    rst = 1;
    load_end = 1;
    tick();
    rst = 0;
    load_end = 0;
    rx_valid = 0;
    foreach (mdl[i]) mdl[i] = 16'h0000;
    q.delete();
    chk("abort_loading", loading, 0);
    chk("abort_done", load_done, 0);
    tick();
    chk("abort_no_pulse", pulses - p0, 0);
    chk("abort_wc", word_count, 0);
    address = 0;
    #1;
    chk("abort_fetch", instruction, 16'h0000);
    pulse_start();
    send_pair(8'hA5, 8'h3C, 1);
    load_start = 1;
    tick();
    load_start = 0;
    chk("wc_mid", word_count, 1);
    send_pair(8'h7E, 8'hC1, 1);
    chk("wc_toggle", word_count, 2);
    stop_session();
    end_session(2);
    pulse_start();
    p0 = pulses;
    for (int k = 0; k < 16; k++) send_pair(8'(k), 8'(k), 0);
    chk("full_done", load_done, 1);
    chk("full_wc", word_count, 16);
    tick();
    chk("full_loading_off", loading, 0);
    chk("full_done_off", load_done, 0);
    chk("full_one_pulse", pulses - p0, 1);
    address = 4'd15;
    #1;
    chk("full_mem15", instruction, 16'h0F0F);
    end_session(16);
    tick();
    chk("wc_hold", word_count, 16);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
